// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// the instruction-fetch port (read-only) and the data port (read/write).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no access in flight; grant sampled at the next edge
// WAIT    | access issued; latency down-counter runs to terminal count
// DONE    | winner's ack is high for this single cycle
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ack,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  grant_dm
);

    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_dm_q, grant_dm_d;
    logic                    op_we_q, op_we_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    if_ack_q, if_ack_d;
    logic                    dm_ack_q, dm_ack_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;
    logic                    any_req;
    logic                    pick_dm;

    assign any_req = if_req | dm_req;
    // On a tie the port that did not win last time takes the grant.
    assign pick_dm = dm_req & (~if_req | ~last_grant_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_dm_d   = grant_dm_q;
        op_we_d      = op_we_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_dm_d   = pick_dm;
                    last_grant_d = pick_dm;
                    op_we_d      = pick_dm & dm_we;
                    mem_en_d     = 1'b1;
                    mem_we_d     = pick_dm & dm_we;
                    mem_addr_d   = pick_dm ? dm_addr : if_addr;
                    mem_wdata_d  = pick_dm ? dm_wdata : '0;
                    cnt_d        = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if_ack_d = ~grant_dm_q;
                    dm_ack_d = grant_dm_q;
                    if (!op_we_q) begin
                        if (grant_dm_q) dm_rdata_d = mem_rdata;
                        else            if_rdata_d = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_dm_q   <= 1'b0;
            op_we_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_dm_q   <= grant_dm_d;
            op_we_q      <= op_we_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_dm  = grant_dm_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 runs with latency 2, instance 1 with
// latency 1; each has its own behavioural memory returning data only in cycle C+L.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    logic [1:0]       if_req, dm_req, dm_we, if_ack, dm_ack, mem_en, mem_we, busy, grant_dm;
    logic [1:0][31:0] if_addr, dm_addr, dm_wdata, if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0]      mem [2][256];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic        pend [2] = '{1'b0, 1'b0};
    int          iss  [2] = '{0, 0};
    logic [31:0] word [2];

    typedef struct {
        int c_en; int c_ack; int n_en; int n_we; int n_ifack; int n_dmack;
        logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic we; logic gdm;
    } obs_t;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) u_lat2 (
        .clock(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
        .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
        .dm_ack(dm_ack[0]), .dm_rdata(dm_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .busy(busy[0]), .grant_dm(grant_dm[0]));

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_lat1 (
        .clock(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
        .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
        .dm_ack(dm_ack[1]), .dm_rdata(dm_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .busy(busy[1]), .grant_dm(grant_dm[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Memory returns the addressed word only in cycle C+L, junk otherwise.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int d = 0; d < 2; d++)
            mem_rdata[d] = (pend[d] && cyc == iss[d] + lat_of(d)) ? word[d] : (32'hBAD0_0000 ^ 32'(cyc));
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            if (mem_en[d] === 1'b1) begin
                pend[d] = 1'b1;
                iss[d]  = cyc;
                word[d] = mem[d][mem_addr[d][9:2]];
            end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        if_req = '0; dm_req = '0; dm_we = '0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_one(input int d, input bit is_dm, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output obs_t o);
        o.c_en = -1; o.c_ack = -1; o.n_en = 0; o.n_we = 0; o.n_ifack = 0; o.n_dmack = 0;
        o.addr = '0; o.wdata = '0; o.rdata = '0; o.we = 1'b0; o.gdm = 1'b0;
        if (is_dm) begin
            dm_req[d] = 1'b1; dm_we[d] = we; dm_addr[d] = addr; dm_wdata[d] = wdata;
        end else begin
            if_req[d] = 1'b1; if_addr[d] = addr;
        end
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (mem_en[d]) begin
                o.n_en++; o.c_en = cyc; o.addr = mem_addr[d]; o.wdata = mem_wdata[d];
                o.we = mem_we[d]; o.gdm = grant_dm[d];
            end
            if (mem_we[d]) o.n_we++;
            if (if_ack[d]) begin o.n_ifack++; o.c_ack = cyc; o.rdata = if_rdata[d]; if_req[d] = 1'b0; end
            if (dm_ack[d]) begin o.n_dmack++; o.c_ack = cyc; o.rdata = dm_rdata[d]; dm_req[d] = 1'b0; end
        end
        if_req[d] = 1'b0;
        dm_req[d] = 1'b0;
    endtask

    task automatic test_reset(input int d);
        do_reset();
        n_cmp++;
        if ({if_ack[d], dm_ack[d], mem_en[d], mem_we[d], busy[d], grant_dm[d]} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl d%0d: got %b want 000000", d,
                              {if_ack[d], dm_ack[d], mem_en[d], mem_we[d], busy[d], grant_dm[d]});
        end
        n_cmp++;
        if ({if_rdata[d], dm_rdata[d], mem_addr[d], mem_wdata[d]} !== 128'b0) begin
            n_bad++; $display("FAIL reset_data d%0d: got %h want 0", d,
                              {if_rdata[d], dm_rdata[d], mem_addr[d], mem_wdata[d]});
        end
    endtask

    task automatic test_fetch(input int d);
        obs_t o;
        int k0;
        int L = lat_of(d);
        do_reset();
        mem[d][1] = 32'h2002_0005;
        k0 = cyc;
        run_one(d, 1'b0, 1'b0, 32'h4, 32'h0, o);
        n_cmp++; if (o.c_en != k0 + 1) begin n_bad++; $display("FAIL fetch_issue d%0d: got %0d want %0d", d, o.c_en, k0 + 1); end
        n_cmp++; if (o.n_en != 1) begin n_bad++; $display("FAIL fetch_en_count d%0d: got %0d want 1", d, o.n_en); end
        n_cmp++; if ({o.addr, o.we, o.gdm} !== {32'h4, 1'b0, 1'b0}) begin n_bad++; $display("FAIL fetch_issue_fields d%0d: got %h/%b/%b want 4/0/0", d, o.addr, o.we, o.gdm); end
        n_cmp++; if (o.n_ifack != 1 || o.n_dmack != 0) begin n_bad++; $display("FAIL fetch_acks d%0d: got if=%0d dm=%0d want 1/0", d, o.n_ifack, o.n_dmack); end
        n_cmp++; if (o.c_ack - o.c_en != L + 1) begin n_bad++; $display("FAIL fetch_ack_lat d%0d: got %0d want %0d", d, o.c_ack - o.c_en, L + 1); end
        n_cmp++; if (o.rdata !== 32'h2002_0005) begin n_bad++; $display("FAIL fetch_rdata d%0d: got %h want 20020005", d, o.rdata); end
    endtask

    task automatic test_write(input int d);
        obs_t o;
        int L = lat_of(d);
        do_reset();
        mem[d][4] = 32'h1122_3344;
        run_one(d, 1'b1, 1'b0, 32'h10, 32'h0, o);
        n_cmp++; if (o.n_dmack != 1 || o.rdata !== 32'h1122_3344) begin n_bad++; $display("FAIL dm_read d%0d: got acks=%0d data=%h want 1/11223344", d, o.n_dmack, o.rdata); end
        run_one(d, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, o);
        n_cmp++; if (o.n_en != 1 || o.n_we != 1) begin n_bad++; $display("FAIL wr_strobes d%0d: got en=%0d we=%0d want 1/1", d, o.n_en, o.n_we); end
        n_cmp++; if ({o.we, o.gdm, o.addr, o.wdata} !== {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL wr_fields d%0d: got %b/%b/%h/%h want 1/1/10/deadbeef", d, o.we, o.gdm, o.addr, o.wdata); end
        n_cmp++; if (o.n_dmack != 1 || o.n_ifack != 0) begin n_bad++; $display("FAIL wr_acks d%0d: got dm=%0d if=%0d want 1/0", d, o.n_dmack, o.n_ifack); end
        n_cmp++; if (o.c_ack - o.c_en != L + 1) begin n_bad++; $display("FAIL wr_ack_lat d%0d: got %0d want %0d", d, o.c_ack - o.c_en, L + 1); end
        n_cmp++; if (dm_rdata[d] !== 32'h1122_3344) begin n_bad++; $display("FAIL wr_rdata_kept d%0d: got %h want 11223344", d, dm_rdata[d]); end
    endtask

    task automatic test_rr(input int d);
        int L = lat_of(d);
        int prev = -1;
        int n_g = 0;
        logic last = 1'b1;
        logic exp_g;
        do_reset();
        mem[d][8]  = 32'hA0A0_0008;
        mem[d][16] = 32'hB0B0_0010;
        if_addr[d] = 32'h20; dm_addr[d] = 32'h40; dm_we[d] = 1'b0;
        if_req[d] = 1'b1; dm_req[d] = 1'b1;
        for (int i = 0; i < 80 && n_g < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (if_ack[d] && dm_ack[d]) begin n_bad++; $display("FAIL rr_dual_ack d%0d: got 11 want not both", d); end
            if (mem_en[d]) begin
                exp_g = ~last;
                n_cmp++; if (grant_dm[d] !== exp_g) begin n_bad++; $display("FAIL rr_grant d%0d #%0d: got %b want %b", d, n_g, grant_dm[d], exp_g); end
                n_cmp++; if (mem_addr[d] !== (exp_g ? 32'h40 : 32'h20)) begin n_bad++; $display("FAIL rr_addr d%0d: got %h want %h", d, mem_addr[d], exp_g ? 32'h40 : 32'h20); end
                if (prev >= 0) begin
                    n_cmp++; if (cyc - prev != L + 3) begin n_bad++; $display("FAIL rr_spacing d%0d: got %0d want %0d", d, cyc - prev, L + 3); end
                end
                prev = cyc; last = exp_g; n_g++;
            end
            if (if_ack[d]) begin n_cmp++; if (if_rdata[d] !== mem[d][8]) begin n_bad++; $display("FAIL rr_if_rdata d%0d: got %h want %h", d, if_rdata[d], mem[d][8]); end end
            if (dm_ack[d]) begin n_cmp++; if (dm_rdata[d] !== mem[d][16]) begin n_bad++; $display("FAIL rr_dm_rdata d%0d: got %h want %h", d, dm_rdata[d], mem[d][16]); end end
        end
        n_cmp++; if (n_g != 6) begin n_bad++; $display("FAIL rr_grant_count d%0d: got %0d want 6", d, n_g); end
        if_req[d] = 1'b0; dm_req[d] = 1'b0;
    endtask

    task automatic test_stream(input int d);
        int L = lat_of(d);
        int prev = -1;
        int n_ack = 0;
        int n_gdm = 0;
        do_reset();
        if_addr[d] = 32'h8; if_req[d] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (grant_dm[d]) n_gdm++;
            if (if_ack[d]) begin
                if (prev >= 0) begin
                    n_cmp++; if (cyc - prev != L + 3) begin n_bad++; $display("FAIL stream_period d%0d: got %0d want %0d", d, cyc - prev, L + 3); end
                end
                prev = cyc; n_ack++;
            end
        end
        n_cmp++; if (n_ack != (40 - (L + 2)) / (L + 3) + 1) begin n_bad++; $display("FAIL stream_count d%0d: got %0d want %0d", d, n_ack, (40 - (L + 2)) / (L + 3) + 1); end
        n_cmp++; if (n_gdm != 0) begin n_bad++; $display("FAIL stream_grant_dm d%0d: got %0d cycles want 0", d, n_gdm); end
        if_req[d] = 1'b0;
    endtask

    task automatic test_reset_mid(input int d);
        obs_t o;
        bit seen = 1'b0;
        int n_ack = 0;
        do_reset();
        mem[d][1] = 32'h5A5A_0001;
        run_one(d, 1'b0, 1'b0, 32'h4, 32'h0, o);
        if_addr[d] = 32'hC; if_req[d] = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_en[d]) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL midrst_issue d%0d: got none want mem_en", d); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; if_req[d] = 1'b0;
        n_cmp++;
        if ({if_ack[d], dm_ack[d], mem_en[d], mem_we[d], busy[d], grant_dm[d]} !== 6'b0) begin
            n_bad++; $display("FAIL midrst_ctrl d%0d: got %b want 000000", d,
                              {if_ack[d], dm_ack[d], mem_en[d], mem_we[d], busy[d], grant_dm[d]});
        end
        n_cmp++;
        if ({if_rdata[d], dm_rdata[d], mem_addr[d], mem_wdata[d]} !== 128'b0) begin
            n_bad++; $display("FAIL midrst_data d%0d: got %h want 0", d,
                              {if_rdata[d], dm_rdata[d], mem_addr[d], mem_wdata[d]});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_ack[d] || dm_ack[d]) n_ack++;
        end
        n_cmp++; if (n_ack != 0) begin n_bad++; $display("FAIL midrst_no_ack d%0d: got %0d want 0", d, n_ack); end
        if_addr[d] = 32'h30; dm_addr[d] = 32'h50; dm_we[d] = 1'b0;
        if_req[d] = 1'b1; dm_req[d] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_en[d]) begin
                seen = 1'b1;
                n_cmp++; if ({grant_dm[d], mem_addr[d]} !== {1'b0, 32'h30}) begin n_bad++; $display("FAIL midrst_first_grant d%0d: got %b/%h want 0/30", d, grant_dm[d], mem_addr[d]); end
            end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL midrst_regrant d%0d: got none want mem_en", d); end
        if_req[d] = 1'b0; dm_req[d] = 1'b0;
    endtask

    // Reference: a grant happens at the first edge with a request once the port
    // is free; the access occupies cycles C..C+L+1 and frees after C+L+2.
    task automatic test_random(input int d);
        int L = lat_of(d);
        int j;
        int free_c;
        int c_acc = -100;
        logic have = 1'b0, own_dm = 1'b0, acc_we = 1'b0, last = 1'b1;
        logic [31:0] acc_addr = '0, acc_wdata = '0, acc_rd = '0, if_rd_exp = '0, dm_rd_exp = '0;
        logic [4:0] exp_v, got_v;
        do_reset();
        for (int i = 0; i < 256; i++) mem[d][i] = $urandom;
        free_c = cyc;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            j = cyc;
            exp_v = {have && j == c_acc, have && j == c_acc && acc_we,
                     have && j == c_acc + L + 1 && !own_dm, have && j == c_acc + L + 1 && own_dm,
                     have && j >= c_acc && j <= c_acc + L + 1};
            got_v = {mem_en[d], mem_we[d], if_ack[d], dm_ack[d], busy[d]};
            n_cmp++; if (got_v !== exp_v) begin n_bad++; $display("FAIL rand_ctrl d%0d cyc %0d: got %b want %b", d, j, got_v, exp_v); end
            if (exp_v[4]) begin
                n_cmp++; if ({grant_dm[d], mem_addr[d]} !== {own_dm, acc_addr}) begin n_bad++; $display("FAIL rand_issue d%0d: got %b/%h want %b/%h", d, grant_dm[d], mem_addr[d], own_dm, acc_addr); end
                if (acc_we) begin n_cmp++; if (mem_wdata[d] !== acc_wdata) begin n_bad++; $display("FAIL rand_wdata d%0d: got %h want %h", d, mem_wdata[d], acc_wdata); end end
            end
            if (exp_v[2]) begin
                if_rd_exp = acc_rd;
                n_cmp++; if (if_rdata[d] !== if_rd_exp) begin n_bad++; $display("FAIL rand_if_rdata d%0d: got %h want %h", d, if_rdata[d], if_rd_exp); end
                if_req[d] = 1'b0;
            end
            if (exp_v[1]) begin
                if (!acc_we) dm_rd_exp = acc_rd;
                n_cmp++; if (dm_rdata[d] !== dm_rd_exp) begin n_bad++; $display("FAIL rand_dm_rdata d%0d: got %h want %h", d, dm_rdata[d], dm_rd_exp); end
                dm_req[d] = 1'b0;
            end
            if (!if_req[d] && $urandom_range(0, 2) == 0) begin
                if_req[d] = 1'b1; if_addr[d] = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!dm_req[d] && $urandom_range(0, 2) == 0) begin
                dm_req[d] = 1'b1; dm_we[d] = 1'($urandom_range(0, 1));
                dm_addr[d] = {22'h0, 8'($urandom_range(0, 255)), 2'b00}; dm_wdata[d] = $urandom;
            end
            if (j >= free_c && (if_req[d] || dm_req[d])) begin
                if (if_req[d] && dm_req[d]) own_dm = ~last;
                else                        own_dm = dm_req[d];
                last = own_dm; have = 1'b1; c_acc = j + 1; free_c = j + L + 3;
                acc_we    = own_dm && dm_we[d];
                acc_addr  = own_dm ? dm_addr[d] : if_addr[d];
                acc_wdata = dm_wdata[d];
                if (acc_we) mem[d][acc_addr[9:2]] = acc_wdata;
                else        acc_rd = mem[d][acc_addr[9:2]];
            end
        end
        if_req[d] = 1'b0; dm_req[d] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        if_req = '0; dm_req = '0; dm_we = '0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        for (int d = 0; d < 2; d++) begin
            test_reset(d);
            test_fetch(d);
            test_write(d);
            test_rr(d);
            test_stream(d);
            test_reset_mid(d);
            test_random(d);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
